bp_predict_push: RTL and testbench

Frontend branch predictor and push side of the branch queue. It accepts decoded control-flow instructions, predicts direction and target from a bimodal BHT and a direct-mapped BTB, and pushes each prediction into the branch queue in program order. It also issues a fetch redirect and trains its tables from committed, resolved branches popped off the branch queue.

---
 rtl/bp_predict_push_pkg.sv | 35 +++
 rtl/bp_predict_push_btb.sv | 43 ++++
 rtl/bp_predict_push.sv | 180 ++++++++++++++++++
 tb/tb_bp_predict_push.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_predict_push_pkg.sv
// Shared types for the frontend branch predictor and the branch queue.
// The BTB entry type is only used when BP_BTB_EN is defined.
package bp_predict_push_pkg;

    localparam int unsigned XLEN               = 64;
    localparam int unsigned ID_BITS            = 6;
    localparam int unsigned DEF_NR_BHT_ENTRIES = 256;
    localparam int unsigned DEF_NR_BTB_ENTRIES = 64;
    localparam int unsigned DEF_BTB_TAG_BITS   = 12;

    typedef logic [XLEN-1:0]    xlen_t;
    typedef logic [ID_BITS-1:0] id_t;

    typedef enum logic [1:0] {
        BK_COND = 2'd0,
        BK_JAL  = 2'd1,
        BK_JALR = 2'd2
    } bp_kind_t;

    typedef struct packed {
        xlen_t pcnext;
        logic  taken;
    } bp_t;

    typedef struct packed {
        logic                        valid;
        logic [DEF_BTB_TAG_BITS-1:0] tag;
        xlen_t                       target;
    } btb_entry_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bp_predict_push_btb.sv
// Direct-mapped JALR target buffer: async lookup, commit write, scrub port.
// Instantiated by bp_predict_push only when BP_BTB_EN is defined.
module bp_btb
    import bp_predict_push_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = DEF_NR_BTB_ENTRIES,
    parameter int unsigned TAG_BITS   = DEF_BTB_TAG_BITS,
    localparam int unsigned IDX_W     = $clog2(NR_ENTRIES)
) (
    input  logic             clk,
    input  xlen_t            i_lookup_pc,
    output logic             o_hit,
    output xlen_t            o_target,
    input  logic             i_wr_en,
    input  xlen_t            i_wr_pc,
    input  xlen_t            i_wr_target,
    input  logic             i_scrub_en,
    input  logic [IDX_W-1:0] i_scrub_idx
);

    btb_entry_t                  r_mem [NR_ENTRIES];
    logic [IDX_W-1:0]            w_lu_idx;
    logic [IDX_W-1:0]            w_wr_idx;
    logic [DEF_BTB_TAG_BITS-1:0] w_lu_tag;
    logic [DEF_BTB_TAG_BITS-1:0] w_wr_tag;

    assign w_lu_idx = i_lookup_pc[IDX_W+1:2];
    assign w_wr_idx = i_wr_pc[IDX_W+1:2];
    assign w_lu_tag = DEF_BTB_TAG_BITS'(i_lookup_pc[IDX_W+2 +: TAG_BITS]);
    assign w_wr_tag = DEF_BTB_TAG_BITS'(i_wr_pc[IDX_W+2 +: TAG_BITS]);

    assign o_hit    = r_mem[w_lu_idx].valid && (r_mem[w_lu_idx].tag == w_lu_tag);
    assign o_target = r_mem[w_lu_idx].target;

    always_ff @(posedge clk) begin
        if (i_scrub_en) begin
            r_mem[i_scrub_idx].valid <= 1'b0;
        end else if (i_wr_en) begin
            r_mem[w_wr_idx] <= '{valid: 1'b1, tag: w_wr_tag, target: i_wr_target};
        end
    end

endmodule

// File: rtl/bp_predict_push.sv
// Bimodal BHT + optional BTB predictor feeding the branch queue push port.
// Define BP_BTB_EN to include the JALR target buffer (bp_btb).
module bp_predict_push
    import bp_predict_push_pkg::*;
#(
    parameter int unsigned NR_BHT_ENTRIES = DEF_NR_BHT_ENTRIES,
    parameter int unsigned NR_BTB_ENTRIES = DEF_NR_BTB_ENTRIES,
    parameter int unsigned BTB_TAG_BITS   = DEF_BTB_TAG_BITS
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     dec_valid,
    output logic     dec_ready,
    input  xlen_t    dec_pc,
    input  id_t      dec_id,
    input  bp_kind_t dec_kind,
    input  xlen_t    dec_target,
    output logic     bq_push_valid,
    input  logic     bq_push_ready,
    output bp_t      bq_push_bp,
    output xlen_t    bq_push_pc,
    output id_t      bq_push_id,
    output logic     redirect_valid,
    output xlen_t    redirect_pc,
    input  logic     commit_valid,
    input  xlen_t    commit_pc,
    input  bp_kind_t commit_kind,
    input  bp_t      commit_bp,
    input  logic     squash_valid
);

    localparam int unsigned BHT_IDX_W = $clog2(NR_BHT_ENTRIES);
`ifdef BP_BTB_EN
    localparam int unsigned BTB_IDX_W = $clog2(NR_BTB_ENTRIES);
    localparam int unsigned SCRUB_LEN = max_u(NR_BHT_ENTRIES, NR_BTB_ENTRIES);
`else
    localparam int unsigned SCRUB_LEN = NR_BHT_ENTRIES;
`endif
    localparam int unsigned SCRUB_W = $clog2(SCRUB_LEN);

    typedef enum logic {StInit, StRun} state_t;

    state_t             r_state;
    logic [SCRUB_W-1:0] r_scrub_idx;
    logic               r_out_valid;
    logic               r_out_redir;
    bp_t                r_out_bp;
    xlen_t              r_out_pc;
    id_t                r_out_id;
    logic [1:0]         r_bht [NR_BHT_ENTRIES];

    logic                 w_run;
    logic                 w_accept;
    logic                 w_fire;
    xlen_t                w_pc_plus4;
    logic [BHT_IDX_W-1:0] w_bht_idx;
    logic [BHT_IDX_W-1:0] w_cm_bht_idx;
    logic [1:0]           w_cm_cnt;
    logic [1:0]           w_cm_cnt_next;
    logic                 w_pred_taken;
    xlen_t                w_pred_pcnext;

    assign w_run          = (r_state == StRun);
    assign dec_ready      = w_run && !squash_valid && (!r_out_valid || bq_push_ready);
    assign w_accept       = dec_valid && dec_ready;
    // Squash suppresses the held entry in the same cycle it is cleared.
    assign bq_push_valid  = r_out_valid && !squash_valid;
    assign w_fire         = bq_push_valid && bq_push_ready;
    assign bq_push_bp     = r_out_bp;
    assign bq_push_pc     = r_out_pc;
    assign bq_push_id     = r_out_id;
    assign redirect_valid = w_fire && r_out_redir;
    assign redirect_pc    = r_out_bp.pcnext;

    assign w_pc_plus4   = dec_pc + xlen_t'(4);
    assign w_bht_idx    = dec_pc[BHT_IDX_W+1:2];
    assign w_cm_bht_idx = commit_pc[BHT_IDX_W+1:2];
    assign w_cm_cnt     = r_bht[w_cm_bht_idx];

`ifdef BP_BTB_EN
    logic  w_btb_hit;
    xlen_t w_btb_target;

    bp_btb #(
        .NR_ENTRIES (NR_BTB_ENTRIES),
        .TAG_BITS   (BTB_TAG_BITS)
    ) u_btb (
        .clk         (clk),
        .i_lookup_pc (dec_pc),
        .o_hit       (w_btb_hit),
        .o_target    (w_btb_target),
        .i_wr_en     (w_run && commit_valid && (commit_kind == BK_JALR)),
        .i_wr_pc     (commit_pc),
        .i_wr_target (commit_bp.pcnext),
        .i_scrub_en  (!w_run),
        .i_scrub_idx (r_scrub_idx[BTB_IDX_W-1:0])
    );
`endif

    always_comb begin
        w_pred_taken  = 1'b0;
        w_pred_pcnext = w_pc_plus4;
        case (dec_kind)
            BK_COND: begin
                w_pred_taken = r_bht[w_bht_idx][1];
                if (w_pred_taken) begin
                    w_pred_pcnext = dec_target;
                end
            end
            BK_JAL: begin
                w_pred_taken  = 1'b1;
                w_pred_pcnext = dec_target;
            end
            BK_JALR: begin
`ifdef BP_BTB_EN
                if (w_btb_hit) begin
                    w_pred_taken  = 1'b1;
                    w_pred_pcnext = w_btb_target;
                end
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        w_cm_cnt_next = w_cm_cnt;
        if (commit_bp.taken) begin
            if (w_cm_cnt != 2'b11) w_cm_cnt_next = w_cm_cnt + 2'b01;
        end else begin
            if (w_cm_cnt != 2'b00) w_cm_cnt_next = w_cm_cnt - 2'b01;
        end
    end

    // Scrub index aliases harmlessly when the BHT is smaller than the scrub length.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_bht[r_scrub_idx[BHT_IDX_W-1:0]] <= 2'b01;
        end else if (commit_valid && (commit_kind == BK_COND)) begin
            r_bht[w_cm_bht_idx] <= w_cm_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StInit;
            r_scrub_idx <= '0;
            r_out_valid <= 1'b0;
            r_out_redir <= 1'b0;
            r_out_bp    <= '0;
            r_out_pc    <= '0;
            r_out_id    <= '0;
        end else begin
            unique case (r_state)
                StInit: begin
                    r_out_valid <= 1'b0;
                    r_scrub_idx <= r_scrub_idx + SCRUB_W'(1);
                    if (r_scrub_idx == SCRUB_W'(SCRUB_LEN - 1)) begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    if (squash_valid) begin
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_out_redir <= (w_pred_pcnext != w_pc_plus4);
                        r_out_bp    <= '{pcnext: w_pred_pcnext, taken: w_pred_taken};
                        r_out_pc    <= dec_pc;
                        r_out_id    <= dec_id;
                    end else if (w_fire) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_predict_push.sv
// Directed + random bench for bp_predict_push against an array-based reference model.
module tb_bp_predict_push;
    import bp_predict_push_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     dec_valid;
    logic     dec_ready;
    xlen_t    dec_pc;
    id_t      dec_id;
    bp_kind_t dec_kind;
    xlen_t    dec_target;
    logic     bq_push_valid;
    logic     bq_push_ready;
    bp_t      bq_push_bp;
    xlen_t    bq_push_pc;
    id_t      bq_push_id;
    logic     redirect_valid;
    xlen_t    redirect_pc;
    logic     commit_valid;
    xlen_t    commit_pc;
    bp_kind_t commit_kind;
    bp_t      commit_bp;
    logic     squash_valid;

    always #5 clk = ~clk;

    bp_predict_push dut (
        .clk            (clk),
        .rst            (rst),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_id         (dec_id),
        .dec_kind       (dec_kind),
        .dec_target     (dec_target),
        .bq_push_valid  (bq_push_valid),
        .bq_push_ready  (bq_push_ready),
        .bq_push_bp     (bq_push_bp),
        .bq_push_pc     (bq_push_pc),
        .bq_push_id     (bq_push_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_kind    (commit_kind),
        .commit_bp      (commit_bp),
        .squash_valid   (squash_valid)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: plain counters and lookup tables indexed from pc arithmetic.
    int          m_bht     [256];
    bit          m_btb_v   [64];
    logic [63:0] m_btb_tag [64];
    logic [63:0] m_btb_tgt [64];
    bit          m_known = 1'b0;
    bit          m_run;
    int          m_scrub_left;
    bit          m_hv;
    logic [63:0] m_h_pcnext;
    bit          m_h_taken;
    logic [63:0] m_h_pc;
    logic [5:0]  m_h_id;
    logic [5:0]  next_id = 6'd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 256; i++) m_bht[i] = 1;
        for (int i = 0; i < 64; i++) m_btb_v[i] = 1'b0;
        m_run        = 1'b0;
        m_scrub_left = 256;
        m_hv         = 1'b0;
        m_h_pcnext   = '0;
        m_h_taken    = 1'b0;
        m_h_pc       = '0;
        m_h_id       = '0;
        m_known      = 1'b1;
    endtask

    task automatic m_predict(input bp_kind_t k, input logic [63:0] pc, input logic [63:0] tgt,
                             output logic [63:0] pn, output bit tk);
        logic [63:0] p4 = pc + 64'd4;
        int          bi = int'((pc >> 2) % 256);
`ifdef BP_BTB_EN
        int          ti = int'((pc >> 2) % 64);
        logic [63:0] tg = (pc >> 8) & 64'hFFF;
`endif
        tk = 1'b0;
        pn = p4;
        if (k == BK_COND) begin
            tk = (m_bht[bi] >= 2);
            pn = tk ? tgt : p4;
        end else if (k == BK_JAL) begin
            tk = 1'b1;
            pn = tgt;
        end else if (k == BK_JALR) begin
`ifdef BP_BTB_EN
            if (m_btb_v[ti] && (m_btb_tag[ti] == tg)) begin
                tk = 1'b1;
                pn = m_btb_tgt[ti];
            end
`endif
        end
    endtask

    task automatic m_train(input bp_kind_t k, input logic [63:0] pc, input bp_t bp);
        int bi = int'((pc >> 2) % 256);
        if (k == BK_COND) begin
            if (bp.taken) m_bht[bi] = (m_bht[bi] == 3) ? 3 : m_bht[bi] + 1;
            else          m_bht[bi] = (m_bht[bi] == 0) ? 0 : m_bht[bi] - 1;
        end
`ifdef BP_BTB_EN
        if (k == BK_JALR) begin
            m_btb_v[(pc >> 2) % 64]   = 1'b1;
            m_btb_tag[(pc >> 2) % 64] = (pc >> 8) & 64'hFFF;
            m_btb_tgt[(pc >> 2) % 64] = bp.pcnext;
        end
`endif
    endtask

    // One clock: compare DUT outputs with the model, then advance both.
    task automatic cycle();
        bit          e_ready;
        bit          e_pv;
        bit          e_fire;
        bit          e_redir;
        logic [63:0] pn;
        bit          tk;
        #1;
        if (m_known) begin
            e_ready = m_run && !squash_valid && (!m_hv || bq_push_ready);
            e_pv    = m_hv && !squash_valid;
            e_fire  = e_pv && bq_push_ready;
            e_redir = e_fire && (m_h_pcnext != m_h_pc + 64'd4);
            chk("dec_ready", 64'(dec_ready), 64'(e_ready));
            chk("push_valid", 64'(bq_push_valid), 64'(e_pv));
            chk("redirect_valid", 64'(redirect_valid), 64'(e_redir));
            if (m_hv) begin
                chk("push_pcnext", bq_push_bp.pcnext, m_h_pcnext);
                chk("push_taken", 64'(bq_push_bp.taken), 64'(m_h_taken));
                chk("push_pc", bq_push_pc, m_h_pc);
                chk("push_id", 64'(bq_push_id), 64'(m_h_id));
            end
            if (e_redir) chk("redirect_pc", redirect_pc, m_h_pcnext);
            if (rst) begin
                m_reset();
            end else if (!m_run) begin
                m_scrub_left--;
                if (m_scrub_left == 0) m_run = 1'b1;
            end else begin
                if (squash_valid) begin
                    m_hv = 1'b0;
                end else if (dec_valid && e_ready) begin
                    m_predict(dec_kind, dec_pc, dec_target, pn, tk);
                    m_hv       = 1'b1;
                    m_h_pcnext = pn;
                    m_h_taken  = tk;
                    m_h_pc     = dec_pc;
                    m_h_id     = dec_id;
                end else if (e_fire) begin
                    m_hv = 1'b0;
                end
                if (commit_valid) m_train(commit_kind, commit_pc, commit_bp);
            end
        end else if (rst) begin
            m_reset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input bp_kind_t k, input logic [63:0] pc, input logic [63:0] tgt);
        dec_valid  = 1'b1;
        dec_kind   = k;
        dec_pc     = pc;
        dec_target = tgt;
        dec_id     = next_id;
        next_id++;
        cycle();
        dec_valid = 1'b0;
    endtask

    task automatic commit(input bp_kind_t k, input logic [63:0] pc, input logic [63:0] pn,
                          input bit tk);
        commit_valid = 1'b1;
        commit_kind  = k;
        commit_pc    = pc;
        commit_bp    = '{pcnext: pn, taken: tk};
        cycle();
        commit_valid = 1'b0;
    endtask

    task automatic expect_push(input string tag, input logic [63:0] pn, input bit tk,
                               input bit redir);
        #1;
        chk({tag, ".valid"}, 64'(bq_push_valid), 64'd1);
        chk({tag, ".pcnext"}, bq_push_bp.pcnext, pn);
        chk({tag, ".taken"}, 64'(bq_push_bp.taken), 64'(tk));
        chk({tag, ".redirect"}, 64'(redirect_valid), 64'(redir));
        if (redir) chk({tag, ".redirect_pc"}, redirect_pc, pn);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".dec_ready"}, 64'(dec_ready), 64'd0);
        chk({tag, ".push_valid"}, 64'(bq_push_valid), 64'd0);
        chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'd0);
        chk({tag, ".push_bp"}, bq_push_bp.pcnext | 64'(bq_push_bp.taken), 64'd0);
        chk({tag, ".push_pc"}, bq_push_pc, 64'd0);
        chk({tag, ".push_id"}, 64'(bq_push_id), 64'd0);
        chk({tag, ".redirect_pc"}, redirect_pc, 64'd0);
    endtask

    task automatic wait_scrub(input string tag);
        int n = 0;
        while (dec_ready !== 1'b1 && n < 1000) begin
            cycle();
            n++;
        end
        chk({tag, ".scrub_cycles"}, 64'(n), 64'd256);
    endtask

    initial begin
        int          k;
        logic [63:0] pc;

        rst           = 1'b1;
        squash_valid  = 1'b0;
        commit_valid  = 1'b0;
        commit_kind   = BK_COND;
        commit_pc     = '0;
        commit_bp     = '0;
        bq_push_ready = 1'b1;
        dec_valid     = 1'b1;
        dec_kind      = BK_COND;
        dec_pc        = 64'h1000;
        dec_target    = 64'h1040;
        dec_id        = 6'd0;
        cycle();
        cycle();
        rst = 1'b0;
        check_reset_outputs("reset");

        // dec_valid held through the scrub; the first accept happens as soon as ready rises
        wait_scrub("init");
        cycle();
        dec_valid = 1'b0;
        expect_push("cond_cold", 64'h1004, 1'b0, 1'b0);
        cycle();

        commit(BK_COND, 64'h1000, 64'h1040, 1'b1);
        commit(BK_COND, 64'h1000, 64'h1040, 1'b1);
        dec(BK_COND, 64'h1000, 64'h1040);
        expect_push("cond_trained", 64'h1040, 1'b1, 1'b1);
        cycle();

        dec(BK_JALR, 64'h2000, 64'h5550);
        expect_push("jalr_miss", 64'h2004, 1'b0, 1'b0);
        cycle();
        commit(BK_JALR, 64'h2000, 64'h8000, 1'b1);
        dec(BK_JALR, 64'h2000, 64'h0);
`ifdef BP_BTB_EN
        expect_push("jalr_hit", 64'h8000, 1'b1, 1'b1);
`else
        expect_push("jalr_nobtb", 64'h2004, 1'b0, 1'b0);
`endif
        cycle();

        // Backpressure: entry held for 5 cycles while a second decode waits
        dec(BK_JAL, 64'h4000, 64'h4100);
        bq_push_ready = 1'b0;
        dec_valid     = 1'b1;
        dec_kind      = BK_JAL;
        dec_pc        = 64'h4004;
        dec_target    = 64'h4200;
        dec_id        = next_id;
        next_id++;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold.valid", 64'(bq_push_valid), 64'd1);
            chk("bp_hold.pcnext", bq_push_bp.pcnext, 64'h4100);
            chk("bp_hold.pc", bq_push_pc, 64'h4000);
            chk("bp_hold.dec_ready", 64'(dec_ready), 64'd0);
            cycle();
        end
        bq_push_ready = 1'b1;
        #1;
        chk("bp_release.redirect", 64'(redirect_valid), 64'd1);
        cycle();
        dec_valid = 1'b0;
        expect_push("bp_next", 64'h4200, 1'b1, 1'b1);
        cycle();

        // Squash with a held entry and a same-cycle COND commit
        dec(BK_COND, 64'h3000, 64'h3100);
        squash_valid = 1'b1;
        commit_valid = 1'b1;
        commit_kind  = BK_COND;
        commit_pc    = 64'h3000;
        commit_bp    = '{pcnext: 64'h3100, taken: 1'b1};
        #1;
        chk("squash.push_valid", 64'(bq_push_valid), 64'd0);
        chk("squash.redirect", 64'(redirect_valid), 64'd0);
        cycle();
        squash_valid = 1'b0;
        commit_valid = 1'b0;
        cycle();
        dec(BK_COND, 64'h3000, 64'h3100);
        expect_push("squash_trained", 64'h3100, 1'b1, 1'b1);
        cycle();

        // Random traffic on pcs whose table entries avoid the directed ones
        for (int i = 0; i < 600; i++) begin
            k  = $urandom_range(1, 16);
            pc = (k == 16) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h6000 + 64'(4 * k);
            dec_valid  = ($urandom_range(0, 9) < 7);
            dec_kind   = bp_kind_t'($urandom_range(0, 2));
            dec_pc     = pc;
            dec_target = ($urandom_range(0, 3) == 0) ? pc + 64'd4
                                                      : {$urandom(), $urandom()} & ~64'd3;
            dec_id     = 6'($urandom_range(0, 63));
            k  = $urandom_range(1, 16);
            pc = (k == 16) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h6000 + 64'(4 * k);
            commit_valid  = ($urandom_range(0, 9) < 4);
            commit_kind   = bp_kind_t'($urandom_range(0, 2));
            commit_pc     = pc;
            commit_bp     = '{pcnext: {$urandom(), $urandom()} & ~64'd3,
                              taken: 1'($urandom_range(0, 1))};
            bq_push_ready = ($urandom_range(0, 3) != 0);
            squash_valid  = ($urandom_range(0, 15) == 0);
            cycle();
        end
        dec_valid     = 1'b0;
        commit_valid  = 1'b0;
        squash_valid  = 1'b0;
        bq_push_ready = 1'b1;
        cycle();

        // Mid-stream reset clears held entry and trained counters
        commit(BK_COND, 64'h1000, 64'h1040, 1'b1);
        bq_push_ready = 1'b0;
        dec(BK_JAL, 64'h1000, 64'h1400);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bq_push_ready = 1'b1;
        check_reset_outputs("mid_reset");
        wait_scrub("rescrub");
        dec(BK_COND, 64'h1000, 64'h1040);
        expect_push("after_reset", 64'h1004, 1'b0, 1'b0);
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
